// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, EX operand-select encodings and the
// bubble instruction word, plus the forwarding-select priority function.
package mips_pkg;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_IDEXA = 2'b00,
        SEL_MEMWB = 2'b01,
        SEL_EXMEM = 2'b10
    } fwd_sel_t;

    // Youngest producer wins; r0 is hard-wired zero and never forwarded.
    function automatic fwd_sel_t fwd_sel(
        input logic [4:0] src,
        input logic       ex_we,
        input logic [4:0] ex_dst,
        input logic       mem_we,
        input logic [4:0] mem_dst
    );
        if (src == 5'd0)                    return SEL_IDEXA;
        else if (ex_we && ex_dst == src)    return SEL_EXMEM;
        else if (mem_we && mem_dst == src)  return SEL_MEMWB;
        else                                return SEL_IDEXA;
    endfunction

endpackage

// File: rtl/fwd_decode.sv
// Combinational instruction classifier: destination register, write/load
// flags and which source fields the instruction actually reads.
module fwd_decode
    import mips_pkg::*;
(
    input  logic [31:11] ir,
    output logic [4:0]   dst,
    output logic         we,
    output logic         ld,
    output logic         rs_used,
    output logic         rt_used
);

    always_comb begin
        dst     = '0;
        we      = 1'b0;
        ld      = 1'b0;
        rs_used = 1'b0;
        rt_used = 1'b0;
        case (ir[31:26])
            OP_ALU: begin
                dst     = ir[15:11];
                we      = 1'b1;
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            OP_LW: begin
                dst     = ir[20:16];
                we      = 1'b1;
                ld      = 1'b1;
                rs_used = 1'b1;
            end
            OP_ADDI: begin
                dst     = ir[20:16];
                we      = 1'b1;
                rs_used = 1'b1;
            end
            OP_SW: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            OP_JAL: begin
                dst = 5'd31;
                we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding select generation and load-use stall, with a shadow
// EX/MEM destination pipeline kept in step with the datapath.
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_IR = NOP_WORD
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ifid_ir,
    input  logic        flush,
    output logic [31:0] idex_ir,
    output logic [1:0]  fa,
    output logic [1:0]  fb,
    output logic [1:0]  fs,
    output logic        stall
);

    logic [4:0] dec_dst;
    logic       dec_we, dec_ld, rs_used, rt_used;

    logic [4:0] ex_dst, mem_dst;
    logic       ex_we, ex_ld, mem_we;

    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       hazard, bubble;
    fwd_sel_t   fa_d, fb_d, fs_d;

    fwd_decode u_dec (
        .ir      (ifid_ir[31:11]),
        .dst     (dec_dst),
        .we      (dec_we),
        .ld      (dec_ld),
        .rs_used (rs_used),
        .rt_used (rt_used)
    );

    always_comb begin
        op     = ifid_ir[31:26];
        rs     = ifid_ir[25:21];
        rt     = ifid_ir[20:16];
        hazard = ex_ld && (ex_dst != 5'd0) &&
                 ((rs_used && ex_dst == rs) || (rt_used && ex_dst == rt));
        // Flush outranks the load-use stall: the squashed instruction needs no wait.
        stall  = hazard && !flush;
        bubble = flush || hazard;
        fa_d   = rs_used        ? fwd_sel(rs, ex_we, ex_dst, mem_we, mem_dst) : SEL_IDEXA;
        fb_d   = (op == OP_ALU) ? fwd_sel(rt, ex_we, ex_dst, mem_we, mem_dst) : SEL_IDEXA;
        fs_d   = (op == OP_SW)  ? fwd_sel(rt, ex_we, ex_dst, mem_we, mem_dst) : SEL_IDEXA;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idex_ir <= NOP_IR;
            fa      <= '0;
            fb      <= '0;
            fs      <= '0;
            ex_dst  <= '0;
            ex_we   <= 1'b0;
            ex_ld   <= 1'b0;
            mem_dst <= '0;
            mem_we  <= 1'b0;
        end else begin
            mem_dst <= ex_dst;
            mem_we  <= ex_we;
            if (bubble) begin
                idex_ir <= NOP_IR;
                fa      <= '0;
                fb      <= '0;
                fs      <= '0;
                ex_dst  <= '0;
                ex_we   <= 1'b0;
                ex_ld   <= 1'b0;
            end else begin
                idex_ir <= ifid_ir;
                fa      <= fa_d;
                fb      <= fb_d;
                fs      <= fs_d;
                ex_dst  <= dec_dst;
                ex_we   <= dec_we;
                ex_ld   <= dec_ld;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit: table of cycles with hand-derived
// stall and registered select expectations, plus a short store/r0 sequence.
module tb_fwd_hazard_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ifid_ir;
    logic        flush;
    logic [31:0] idex_ir;
    logic [1:0]  fa, fb, fs;
    logic        stall;

    int passed = 0;
    int total  = 0;

    fwd_hazard_unit #(.NOP_IR(32'h0000_0000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ifid_ir (ifid_ir),
        .flush   (flush),
        .idex_ir (idex_ir),
        .fa      (fa),
        .fb      (fb),
        .fs      (fs),
        .stall   (stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir;
        logic        flush;
        logic        rst_n;
        logic        chk_stall;
        logic        stall;
        logic [31:0] idex;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  fs;
    } vec_t;

    function automatic logic [31:0] rtype(input int unsigned rs, input int unsigned rt,
                                          input int unsigned rd, input int unsigned funct);
        logic [31:0] w;
        w = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct[5:0]};
        return w;
    endfunction

    function automatic logic [31:0] itype(input int unsigned op, input int unsigned rs,
                                          input int unsigned rt, input int unsigned imm);
        logic [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
        return w;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    endtask

    // Drive one cycle: stall is checked before the edge, registered outputs after it.
    task automatic run(input vec_t v, input int idx);
        ifid_ir = v.ir;
        flush   = v.flush;
        reset_n = v.rst_n;
        #1;
        if (v.chk_stall) chk("stall", idx, {31'd0, stall}, {31'd0, v.stall});
        @(posedge clock);
        #1;
        chk("idex_ir", idx, idex_ir, v.idex);
        chk("fa", idx, {30'd0, fa}, {30'd0, v.fa});
        chk("fb", idx, {30'd0, fb}, {30'd0, v.fb});
        chk("fs", idx, {30'd0, fs}, {30'd0, v.fs});
    endtask

    function automatic vec_t mk(input logic [31:0] ir, input logic fl, input logic rn,
                                input logic cs, input logic st, input logic [31:0] idex,
                                input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
        vec_t v;
        v.ir = ir; v.flush = fl; v.rst_n = rn; v.chk_stall = cs; v.stall = st;
        v.idex = idex; v.fa = a; v.fb = b; v.fs = s;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        logic [31:0] add3, sub5, or10, and6, lw2, add4, addi7a, addi7b, sw7, add0, add8;
        logic [31:0] lw7, sw7b, lw0, add4r0;

        add3   = rtype(1, 2, 3, 'h20);
        sub5   = rtype(3, 4, 5, 'h22);
        or10   = rtype(8, 9, 10, 'h25);
        and6   = rtype(4, 3, 6, 'h24);
        lw2    = itype('h23, 1, 2, 0);
        add4   = rtype(2, 5, 4, 'h20);
        addi7a = itype('h08, 1, 7, 5);
        addi7b = itype('h08, 7, 7, 1);
        sw7    = itype('h2B, 1, 7, 4);
        add0   = rtype(1, 2, 0, 'h20);
        add8   = rtype(0, 0, 8, 'h20);

        ifid_ir = '0;
        flush   = 1'b0;
        reset_n = 1'b0;

        //          ir      fl  rn  cs  st  idex    fa     fb     fs
        tbl.push_back(mk('0,     0, 0, 1, 0, '0,     2'b00, 2'b00, 2'b00)); // reset
        tbl.push_back(mk(add3,   0, 1, 1, 0, add3,   2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(sub5,   0, 1, 1, 0, sub5,   2'b10, 2'b00, 2'b00)); // EX forward
        tbl.push_back(mk(add3,   0, 1, 1, 0, add3,   2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(or10,   0, 1, 1, 0, or10,   2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(and6,   0, 1, 1, 0, and6,   2'b00, 2'b01, 2'b00)); // MEM forward on rt
        tbl.push_back(mk(lw2,    0, 1, 1, 0, lw2,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(add4,   0, 1, 1, 1, '0,     2'b00, 2'b00, 2'b00)); // load-use stall
        tbl.push_back(mk(add4,   0, 1, 1, 0, add4,   2'b01, 2'b00, 2'b00)); // released, lw in MEM
        tbl.push_back(mk(or10,   0, 1, 1, 0, or10,   2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(addi7a, 0, 1, 1, 0, addi7a, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(addi7b, 0, 1, 1, 0, addi7b, 2'b10, 2'b00, 2'b00));
        tbl.push_back(mk(sw7,    0, 1, 1, 0, sw7,    2'b00, 2'b00, 2'b10)); // EX beats MEM
        tbl.push_back(mk(add0,   0, 1, 1, 0, add0,   2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(add8,   0, 1, 1, 0, add8,   2'b00, 2'b00, 2'b00)); // r0 never forwarded
        tbl.push_back(mk(lw2,    0, 1, 1, 0, lw2,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(add4,   1, 1, 1, 0, '0,     2'b00, 2'b00, 2'b00)); // flush beats stall
        tbl.push_back(mk(or10,   0, 1, 1, 0, or10,   2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(lw2,    0, 1, 1, 0, lw2,    2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(add4,   0, 0, 0, 0, '0,     2'b00, 2'b00, 2'b00)); // reset mid-stall
        tbl.push_back(mk(add4,   0, 1, 1, 0, add4,   2'b00, 2'b00, 2'b00)); // no stale forward

        foreach (tbl[i]) run(tbl[i], i);

        // Store data load-use on rt, then a load into r0 must not stall.
        lw7    = itype('h23, 1, 7, 0);
        sw7b   = itype('h2B, 1, 7, 0);
        lw0    = itype('h23, 1, 0, 0);
        add4r0 = rtype(0, 5, 4, 'h20);
        run(mk(lw7,    0, 1, 1, 0, lw7,    2'b00, 2'b00, 2'b00), 100);
        run(mk(sw7b,   0, 1, 1, 1, '0,     2'b00, 2'b00, 2'b00), 101);
        run(mk(sw7b,   0, 1, 1, 0, sw7b,   2'b00, 2'b00, 2'b01), 102);
        run(mk(lw0,    0, 1, 1, 0, lw0,    2'b00, 2'b00, 2'b00), 103);
        run(mk(add4r0, 0, 1, 1, 0, add4r0, 2'b00, 2'b00, 2'b00), 104);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
